// File: rtl/adc_responder.sv
// ---------------------------------------------------------------------------
// adc_responder
//   Emulates an 8-channel, 10-bit MCP3008-style ADC on the device side of an
//   SPI link. The SPI pins are oversampled on clk_i. The responder returns a
//   per-channel ramp for single-ended conversions and mid-scale (10'h200) for
//   differential ones. After each completed single-ended conversion the ramp
//   of that channel advances by STEP, wrapping mod 1024.
//
// Parameters
//   STEP        ramp increment after a completed single-ended conversion
//   SYNC_STAGES synchronizer depth on sclk_i / cs_n_i / din_i (>= 2)
//   MSB_FIRST   1: shift B9..B0, 0: shift B0..B9
//
// Ports
//   clk_i, rst_n_i  system clock (>= 8x sclk), async active-low reset
//   sclk_i, cs_n_i  SPI clock and active-low chip select from the master
//   din_i           command bits, taken on sclk rising edges
//   dout_o          data bits, updated after sclk falling edges
//   dout_oe_o       pad output enable, high while a frame is selected
//   busy_o          high from the start bit until frame end or abort
//   conv_done_o     one-clk pulse once the last data bit has been shifted
//   last_ch_o       channel of the last completed conversion
//   last_data_o     value of the last completed conversion
//   err_o           one-clk pulse when cs_n rises after the start bit
//   state_o         current FSM state (debug visibility)
//
// Optional feature (macro ADC_EXT_SAMPLE_EN)
//   Adds ext_data_i[9:0] / ext_sel_i. When ext_sel_i is high at the sample
//   point, ext_data_i is returned instead and no ramp advances.
// ---------------------------------------------------------------------------
module adc_responder #(
  parameter int unsigned STEP        = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       din_i,
`ifdef ADC_EXT_SAMPLE_EN
  input  logic [9:0] ext_data_i,
  input  logic       ext_sel_i,
`endif
  output logic       dout_o,
  output logic       dout_oe_o,
  output logic       busy_o,
  output logic       conv_done_o,
  output logic [2:0] last_ch_o,
  output logic [9:0] last_data_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_CONFIG     = 3'd2,
    S_SAMPLE     = 3'd3,
    S_DATA       = 3'd4,
    S_DONE       = 3'd5,
    S_TRAIL      = 3'd6
  } state_e;

  // Input synchronizers; the last stage is the usable level.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   sclk_s, cs_s, din_s, rise, fall;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cfg_q, cfg_d;       // {SGL, D2, D1, D0}
  logic [9:0] conv_q, conv_d;
  logic       ext_q, ext_d;       // conversion came from the external input
  logic       dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [2:0] last_ch_q, last_ch_d;
  logic [9:0] last_data_q, last_data_d;
  logic [9:0] ramp_q [8];
  logic [9:0] ramp_d [8];
  logic [3:0] bit_idx;

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
  assign din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], din_i};
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign din_s       = din_sync_q[SYNC_STAGES-1];
  assign sclk_prev_d = sclk_s;
  assign rise        = sclk_s & ~sclk_prev_q;
  assign fall        = ~sclk_s & sclk_prev_q;
  assign bit_idx     = MSB_FIRST ? (4'd9 - cnt_q) : cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_d       = cfg_q;
    conv_d      = conv_q;
    ext_d       = ext_q;
    dout_d      = dout_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    last_ch_d   = last_ch_q;
    last_data_d = last_data_q;
    ramp_d      = ramp_q;

    case (state_q)
      S_IDLE: begin
        dout_d = 1'b0;
        cnt_d  = 4'd0;
        if (!cs_s) state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        dout_d = 1'b0;
        if (cs_s) begin
          state_d = S_IDLE;   // no start bit yet, so no error pulse
        end else if (rise && din_s) begin
          state_d = S_CONFIG;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      S_CONFIG, S_SAMPLE, S_DATA: begin
        // cs_n rising takes priority over any sclk edge in the same cycle.
        if (cs_s) begin
          state_d = S_IDLE;
          err_d   = busy_q;
          busy_d  = 1'b0;
          dout_d  = 1'b0;
        end else if (state_q == S_CONFIG) begin
          if (rise) begin
            cfg_d = {cfg_q[2:0], din_s};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd3) state_d = S_SAMPLE;
          end
        end else if (state_q == S_SAMPLE) begin
          if (fall) begin
            conv_d = cfg_q[3] ? ramp_q[cfg_q[2:0]] : 10'h200;
            ext_d  = 1'b0;
`ifdef ADC_EXT_SAMPLE_EN
            if (ext_sel_i) begin
              conv_d = ext_data_i;
              ext_d  = 1'b1;
            end
`endif
            dout_d  = 1'b0;     // null bit
            cnt_d   = 4'd0;
            state_d = S_DATA;
          end
        end else begin
          if (fall && cnt_q != 4'd10) begin
            dout_d = conv_q[bit_idx];
            cnt_d  = cnt_q + 4'd1;
          end else if (rise && cnt_q == 4'd10) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        last_ch_d   = cfg_q[2:0];
        last_data_d = conv_q;
        if (cfg_q[3] && !ext_q) begin
          ramp_d[cfg_q[2:0]] = ramp_q[cfg_q[2:0]] + 10'(STEP);
        end
        state_d = S_TRAIL;
      end
      S_TRAIL: begin
        dout_d = 1'b0;
        if (cs_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Enable follows the next state so it drops the cycle after an abort.
  assign oe_d = (state_d != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      cfg_q       <= 4'd0;
      conv_q      <= 10'd0;
      ext_q       <= 1'b0;
      dout_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_ch_q   <= 3'd0;
      last_data_q <= 10'd0;
      for (int i = 0; i < 8; i++) ramp_q[i] <= 10'(i * 128);
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      din_sync_q  <= din_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      conv_q      <= conv_d;
      ext_q       <= ext_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_ch_q   <= last_ch_d;
      last_data_q <= last_data_d;
      ramp_q      <= ramp_d;
    end
  end

  assign dout_o      = dout_q;
  assign dout_oe_o   = oe_q;
  assign busy_o      = busy_q;
  assign conv_done_o = done_q;
  assign err_o       = err_q;
  assign last_ch_o   = last_ch_q;
  assign last_data_o = last_data_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_adc_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_responder
//   Drives SPI frames into two responders sharing the same pins (STEP=1 and
//   STEP=64) and checks the returned words, status outputs and last_* values
//   against a per-channel ramp model kept in the bench.
// ---------------------------------------------------------------------------
module tb_adc_responder;

  localparam int HALF = 8;   // clk cycles per sclk half period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic din = 1'b0;

  always #5 clk = ~clk;

  logic       dout_a, oe_a, busy_a, done_a, err_a;
  logic [2:0] lch_a, st_a;
  logic [9:0] ldat_a;
  logic       dout_b, oe_b, busy_b, done_b, err_b;
  logic [2:0] lch_b, st_b;
  logic [9:0] ldat_b;

  adc_responder #(.STEP(1), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .sclk_i(sclk), .cs_n_i(cs_n), .din_i(din),
    .dout_o(dout_a), .dout_oe_o(oe_a), .busy_o(busy_a), .conv_done_o(done_a),
    .last_ch_o(lch_a), .last_data_o(ldat_a), .err_o(err_a), .state_o(st_a)
  );

  adc_responder #(.STEP(64), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .sclk_i(sclk), .cs_n_i(cs_n), .din_i(din),
    .dout_o(dout_b), .dout_oe_o(oe_b), .busy_o(busy_b), .conv_done_o(done_b),
    .last_ch_o(lch_b), .last_data_o(ldat_b), .err_o(err_b), .state_o(st_b)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [9:0]  ramp_a [8];
  logic [9:0]  ramp_b [8];
  logic [12:0] exp_qa[$];   // {ch, data} expected at each conv_done
  logic [12:0] exp_qb[$];
  logic [12:0] last_exp_a = '0;
  logic [12:0] last_exp_b = '0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int err_cnt_a = 0, err_cnt_b = 0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      ramp_a[i] = 10'(i * 128);
      ramp_b[i] = 10'(i * 128);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      last_exp_a = '0;
      last_exp_b = '0;
    end else begin
      if (done_a) begin
        chk("done_a_expected", 32'(exp_qa.size() != 0), 1);
        if (exp_qa.size() != 0) last_exp_a = exp_qa.pop_front();
        done_cnt_a++;
        chk("busy_a_at_done", busy_a, 0);
      end
      if (done_b) begin
        chk("done_b_expected", 32'(exp_qb.size() != 0), 1);
        if (exp_qb.size() != 0) last_exp_b = exp_qb.pop_front();
        done_cnt_b++;
        chk("busy_b_at_done", busy_b, 0);
      end
      if (err_a) err_cnt_a++;
      if (err_b) err_cnt_b++;
    end
    chk("last_a", {lch_a, ldat_a}, last_exp_a);
    chk("last_b", {lch_b, ldat_b}, last_exp_b);
  end

  // ---------------- driver ----------------
  // stop_mode: 0 full frame, 1 raise cs_n after stop_bits data bits,
  // 2 assert reset after stop_bits data bits.
  task automatic run_frame(input logic sgl, input logic [2:0] ch, input int lead,
                           input int stop_mode, input int stop_bits,
                           output logic [9:0] wa, output logic [9:0] wb);
    logic [4:0] cmd;
    int n;
    cmd = {1'b1, sgl, ch};
    n = lead + 16;
    wa = '0;
    wb = '0;
    cs_n = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k >= lead && k < lead + 5) din = cmd[4 - (k - lead)];
      else din = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
      if (stop_mode != 0 && k == lead + 6 + stop_bits) begin
        if (stop_mode == 1) cs_n = 1'b1;
        else rst_n = 1'b0;
        return;
      end
      chk("busy_a", busy_a, 32'(k > lead));
      chk("busy_b", busy_b, 32'(k > lead));
      if (k == 0) begin
        chk("oe_a_frame", oe_a, 1);
        chk("oe_b_frame", oe_b, 1);
      end
      if (k <= lead + 5) begin
        chk("dout_a_pre", dout_a, 0);
        chk("dout_b_pre", dout_b, 0);
      end else begin
        wa[9 - (k - lead - 6)] = dout_a;
        wb[9 - (k - lead - 6)] = dout_b;
      end
      sclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      sclk = 1'b0;
    end
    repeat (HALF) @(posedge clk);
    #1;
    cs_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("oe_a_end", oe_a, 0);
    chk("oe_b_end", oe_b, 0);
    chk("busy_a_end", busy_a, 0);
    chk("busy_b_end", busy_b, 0);
    chk("dout_a_end", dout_a, 0);
  endtask

  // Full frame with model prediction and ramp advance.
  task automatic do_frame(input logic sgl, input logic [2:0] ch, input int lead,
                          output logic [9:0] wa, output logic [9:0] wb);
    logic [9:0] ea, eb;
    int da, db;
    ea = sgl ? ramp_a[ch] : 10'h200;
    eb = sgl ? ramp_b[ch] : 10'h200;
    exp_qa.push_back({ch, ea});
    exp_qb.push_back({ch, eb});
    da = done_cnt_a;
    db = done_cnt_b;
    run_frame(sgl, ch, lead, 0, 0, wa, wb);
    chk("word_a", wa, ea);
    chk("word_b", wb, eb);
    chk("done_cnt_a", done_cnt_a - da, 1);
    chk("done_cnt_b", done_cnt_b - db, 1);
    if (sgl) begin
      ramp_a[ch] = 10'((ramp_a[ch] + 1) % 1024);
      ramp_b[ch] = 10'((ramp_b[ch] + 64) % 1024);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout_a"}, dout_a, 0);
    chk({tag, "_oe_a"}, oe_a, 0);
    chk({tag, "_busy_a"}, busy_a, 0);
    chk({tag, "_done_a"}, done_a, 0);
    chk({tag, "_err_a"}, err_a, 0);
    chk({tag, "_last_a"}, {lch_a, ldat_a}, 0);
    chk({tag, "_dout_b"}, dout_b, 0);
    chk({tag, "_oe_b"}, oe_b, 0);
    chk({tag, "_busy_b"}, busy_b, 0);
    chk({tag, "_last_b"}, {lch_b, ldat_b}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] wa, wb;
    int ea0, eb0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // ch0 single-ended twice: ramp start and +STEP
    do_frame(1'b1, 3'd0, 0, wa, wb);
    chk("lit_ch0_first", wa, 10'h000);
    do_frame(1'b1, 3'd0, 0, wa, wb);
    chk("lit_ch0_second_a", wa, 10'h001);
    chk("lit_ch0_second_b", wb, 10'h040);

    // ch5
    do_frame(1'b1, 3'd5, 0, wa, wb);
    chk("lit_ch5", wa, 10'h280);
    chk("lit_ch5_last", ldat_a, 10'h280);
    do_frame(1'b1, 3'd5, 0, wa, wb);
    chk("lit_ch5_ramp", wa, 10'h281);

    // differential twice, ramp[7] untouched
    do_frame(1'b0, 3'd7, 0, wa, wb);
    chk("lit_diff1", wa, 10'h200);
    do_frame(1'b0, 3'd7, 0, wa, wb);
    chk("lit_diff2", wa, 10'h200);
    do_frame(1'b1, 3'd7, 0, wa, wb);
    chk("lit_ch7_a", wa, 10'h380);
    chk("lit_ch7_b", wb, 10'h380);

    // leading zeros before the start bit
    do_frame(1'b1, 3'd2, 3, wa, wb);
    chk("lit_ch2_lead", wa, 10'h100);

    // select without a start bit: no busy, no error
    ea0 = err_cnt_a;
    cs_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
      chk("ws_busy_a", busy_a, 0);
      chk("ws_oe_a", oe_a, 1);
      sclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      sclk = 1'b0;
    end
    cs_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("ws_oe_a_off", oe_a, 0);
    chk("ws_no_err_a", err_cnt_a - ea0, 0);

    // abort after 4 data bits of ch3
    ea0 = err_cnt_a;
    eb0 = err_cnt_b;
    run_frame(1'b1, 3'd3, 0, 1, 4, wa, wb);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_err_a", err_cnt_a - ea0, 1);
    chk("abort_err_b", err_cnt_b - eb0, 1);
    chk("abort_oe_a", oe_a, 0);
    chk("abort_oe_b", oe_b, 0);
    chk("abort_busy_a", busy_a, 0);
    chk("abort_bits_a", wa[9:6], ramp_a[3][9:6]);
    do_frame(1'b1, 3'd3, 0, wa, wb);
    chk("lit_ch3_after_abort", wa, 10'h180);

    // STEP=64 wrap on ch7
    do_frame(1'b1, 3'd7, 0, wa, wb);
    chk("lit_ch7_b_3c0", wb, 10'h3C0);
    do_frame(1'b1, 3'd7, 0, wa, wb);
    chk("lit_ch7_b_wrap", wb, 10'h000);
    chk("lit_ch7_a_382", wa, 10'h382);

    // reset during DATA
    run_frame(1'b1, 3'd7, 0, 2, 3, wa, wb);
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    cs_n = 1'b1;
    rst_n = 1'b1;
    model_reset();
    repeat (6) @(posedge clk);
    #1;
    do_frame(1'b1, 3'd7, 0, wa, wb);
    chk("lit_ch7_after_rst_a", wa, 10'h380);
    chk("lit_ch7_after_rst_b", wb, 10'h380);

    repeat (4) @(posedge clk);
    #1;
    chk("exp_qa_empty", exp_qa.size(), 0);
    chk("exp_qb_empty", exp_qb.size(), 0);
    chk("err_total_a", err_cnt_a, 1);
    chk("err_total_b", err_cnt_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
